mby_msh_wr_req_rcvr: RTL and testbench

Receive-side endpoint of one mesh write-request link: the far end of a mesh node's o_*_wr_req / o_*_wr_dbus outputs and the source of the matching credit return.
Captures each write request, aligns it with its data bus (which lags the request by a fixed latency), and buffers the pair in a credit-sized FIFO.
Presents the pair to a local consumer with valid/ready and returns one credit per dequeued entry.
Instantiated once per mesh port direction at plane/edge endpoints and in the node-level bench as a credit-accurate sink.

---
 rtl/mby_msh_pkg.sv | 19 +
 rtl/mby_msh_crdt_fifo.sv | 54 +++++
 rtl/mby_msh_wr_req_rcvr.sv | 101 ++++++++++
 tb/tb_mby_msh_wr_req_rcvr.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mby_msh_pkg.sv
// Mesh write-path types and constants shared by senders, receivers
// and the transmitter-side credit counters.
package mby_msh_pkg;

  localparam int MSH_WR_REQ_W   = 64;
  localparam int MSH_WR_DATA_W  = 512;
  localparam int MSH_CRDT_DEPTH = 8;

  typedef struct packed {
    logic [7:0]  tag;
    logic [7:0]  len;
    logic [47:0] addr;
  } msh_wr_req_t;

  function automatic int msh_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mby_msh_crdt_fifo.sv
// Show-ahead credit FIFO with wrap-bit pointers; shared by the
// wr_req, rd_req and rd_rsp receivers.
module mby_msh_crdt_fifo
  import mby_msh_pkg::*;
#(
  parameter int DEPTH = MSH_CRDT_DEPTH,
  parameter int W     = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          push_i,
  input  logic [W-1:0]                  push_data_i,
  input  logic                          pop_i,
  output logic [W-1:0]                  head_o,
  output logic                          empty_o,
  output logic                          full_o,
  output logic [msh_cnt_w(DEPTH)-1:0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  assign empty_o = wr_ptr_q == rd_ptr_q;
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;

  // A pop frees the head slot, so a full FIFO can still take a push.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  assign head_o   = mem_q[rd_ptr_q[AW-1:0]];
  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/mby_msh_wr_req_rcvr.sv
// Mesh write-request receiver: aligns request with lagging data bus,
// buffers the pair and returns one credit per dequeued entry.
module mby_msh_wr_req_rcvr
  import mby_msh_pkg::*;
#(
  parameter int DEPTH    = MSH_CRDT_DEPTH,
  parameter int REQ_W    = MSH_WR_REQ_W,
  parameter int DATA_W   = MSH_WR_DATA_W,
  parameter int DBUS_LAT = 1
) (
  input  logic                     mclk,
  input  logic                     mhreset_n,
  input  logic                     i_wr_req_vld,
  input  logic [REQ_W-1:0]         i_wr_req,
  input  logic [DATA_W-1:0]        i_wr_dbus,
  output logic                     o_req_vld,
  output logic [REQ_W-1:0]         o_req,
  output logic [DATA_W-1:0]        o_dbus,
  input  logic                     i_req_rdy,
  output logic                     o_crdt_rtn,
  output logic [$clog2(DEPTH):0]   o_occupancy,
  output logic                     o_overflow_err
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]    occ_q, occ_d;
  logic             crdt_q, ovf_q;
  logic             pop, accept, drop;
  logic             wr_vld;
  logic [REQ_W-1:0] wr_req;
  logic             fifo_empty, fifo_full;
  logic [CW-1:0]    fifo_cnt;
  logic             unused_fifo;

  assign pop    = o_req_vld & i_req_rdy;
  assign accept = i_wr_req_vld & ((occ_q != CW'(DEPTH)) | pop);
  assign drop   = i_wr_req_vld & ~accept;
  assign occ_d  = occ_q + CW'(accept) - CW'(pop);

  // Requests ride the pipe until their data shows up on the bus.
  if (DBUS_LAT == 0) begin : g_nopipe
    assign wr_vld = accept;
    assign wr_req = i_wr_req;
  end else begin : g_pipe
    logic [DBUS_LAT-1:0] vld_q;
    logic [REQ_W-1:0]    req_q [DBUS_LAT];

    always_ff @(posedge mclk or negedge mhreset_n) begin
      if (!mhreset_n) begin
        vld_q <= '0;
        for (int i = 0; i < DBUS_LAT; i++) req_q[i] <= '0;
      end else begin
        vld_q[0] <= accept;
        req_q[0] <= i_wr_req;
        for (int i = 1; i < DBUS_LAT; i++) begin
          vld_q[i] <= vld_q[i-1];
          req_q[i] <= req_q[i-1];
        end
      end
    end

    assign wr_vld = vld_q[DBUS_LAT-1];
    assign wr_req = req_q[DBUS_LAT-1];
  end

  mby_msh_crdt_fifo #(
    .DEPTH (DEPTH),
    .W     (REQ_W + DATA_W)
  ) u_fifo (
    .clk_i       (mclk),
    .rst_ni      (mhreset_n),
    .push_i      (wr_vld),
    .push_data_i ({wr_req, i_wr_dbus}),
    .pop_i       (pop),
    .head_o      ({o_req, o_dbus}),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .count_o     (fifo_cnt)
  );

  assign unused_fifo = fifo_full ^ (^fifo_cnt);

  always_ff @(posedge mclk or negedge mhreset_n) begin
    if (!mhreset_n) begin
      occ_q  <= '0;
      crdt_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      occ_q  <= occ_d;
      crdt_q <= pop;
      ovf_q  <= ovf_q | drop;
    end
  end

  assign o_req_vld      = ~fifo_empty;
  assign o_crdt_rtn     = crdt_q;
  assign o_occupancy    = occ_q;
  assign o_overflow_err = ovf_q;

endmodule

// File: tb/tb_mby_msh_wr_req_rcvr.sv
// Directed bench for the mesh write-request receiver at DBUS_LAT 1, 0
// and 3; index 0 -> lat1, 1 -> lat0, 2 -> lat3.
module tb_mby_msh_wr_req_rcvr;

  logic         mclk = 1'b0;
  logic         mhreset_n;
  logic         vld   [3];
  logic         rdy   [3];
  logic [63:0]  req   [3];
  logic [511:0] dbus  [3];
  logic         ovld  [3];
  logic         crdt  [3];
  logic         oerr  [3];
  logic [63:0]  oreq  [3];
  logic [511:0] odbus [3];
  logic [3:0]   occ   [3];
  logic [511:0] sched [3][4];
  int           lat   [3] = '{1, 0, 3};
  int           total = 0;
  int           bad   = 0;

  always #5 mclk = ~mclk;

  mby_msh_wr_req_rcvr #(.DBUS_LAT(1)) u_lat1 (
    .mclk(mclk), .mhreset_n(mhreset_n),
    .i_wr_req_vld(vld[0]), .i_wr_req(req[0]), .i_wr_dbus(dbus[0]),
    .o_req_vld(ovld[0]), .o_req(oreq[0]), .o_dbus(odbus[0]),
    .i_req_rdy(rdy[0]), .o_crdt_rtn(crdt[0]),
    .o_occupancy(occ[0]), .o_overflow_err(oerr[0]));

  mby_msh_wr_req_rcvr #(.DBUS_LAT(0)) u_lat0 (
    .mclk(mclk), .mhreset_n(mhreset_n),
    .i_wr_req_vld(vld[1]), .i_wr_req(req[1]), .i_wr_dbus(dbus[1]),
    .o_req_vld(ovld[1]), .o_req(oreq[1]), .o_dbus(odbus[1]),
    .i_req_rdy(rdy[1]), .o_crdt_rtn(crdt[1]),
    .o_occupancy(occ[1]), .o_overflow_err(oerr[1]));

  mby_msh_wr_req_rcvr #(.DBUS_LAT(3)) u_lat3 (
    .mclk(mclk), .mhreset_n(mhreset_n),
    .i_wr_req_vld(vld[2]), .i_wr_req(req[2]), .i_wr_dbus(dbus[2]),
    .o_req_vld(ovld[2]), .o_req(oreq[2]), .o_dbus(odbus[2]),
    .i_req_rdy(rdy[2]), .o_crdt_rtn(crdt[2]),
    .o_occupancy(occ[2]), .o_overflow_err(oerr[2]));

  // Advance one cycle; data scheduled for this cycle goes on the bus.
  task automatic step();
    @(posedge mclk);
    #1;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 3; j++) sched[k][j] = sched[k][j+1];
      sched[k][3] = '0;
      dbus[k] = sched[k][0];
      vld[k] = 1'b0;
    end
  endtask

  task automatic send(input int k, input logic [63:0] r,
                      input logic [511:0] d);
    vld[k] = 1'b1;
    req[k] = r;
    sched[k][lat[k]] = d;
    dbus[k] = sched[k][0];
  endtask

  task automatic load8(input int k, input logic [63:0] rb,
                       input logic [511:0] db);
    for (int i = 0; i < 8; i++) begin
      send(k, rb + 64'(i), db + 512'(i));
      step();
    end
    repeat (lat[k]) step();
  endtask

  task automatic test_reset();
    mhreset_n = 1'b0;
    repeat (3) @(posedge mclk);
    #1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if ({ovld[k], crdt[k], occ[k], oerr[k]} !== 7'd0) begin
        bad++;
        $display("FAIL reset%0d outs got=%0h exp=0", k,
                 {ovld[k], crdt[k], occ[k], oerr[k]});
      end
    end
    @(negedge mclk) mhreset_n = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      total++;
      if ({ovld[k], crdt[k], occ[k], oerr[k]} !== 7'd0) begin
        bad++;
        $display("FAIL post_reset%0d outs got=%0h exp=0", k,
                 {ovld[k], crdt[k], occ[k], oerr[k]});
      end
    end
  endtask

  task automatic test_single();
    rdy[0] = 1'b1;
    send(0, 64'hA5, 512'h1234);
    total++;
    if (ovld[0] !== 1'b0 || occ[0] !== 4'd0) begin
      bad++;
      $display("FAIL single_t0 vld=%0b occ=%0d exp vld=0 occ=0",
               ovld[0], occ[0]);
    end
    step();
    total++;
    if (ovld[0] !== 1'b0 || occ[0] !== 4'd1) begin
      bad++;
      $display("FAIL single_t1 vld=%0b occ=%0d exp vld=0 occ=1",
               ovld[0], occ[0]);
    end
    step();
    total++;
    if (ovld[0] !== 1'b1 || oreq[0] !== 64'hA5 ||
        odbus[0] !== 512'h1234) begin
      bad++;
      $display("FAIL single_head vld=%0b req=%0h dbus=%0h exp 1 a5 1234",
               ovld[0], oreq[0], odbus[0]);
    end
    total++;
    if (occ[0] !== 4'd1 || crdt[0] !== 1'b0) begin
      bad++;
      $display("FAIL single_t2 occ=%0d crdt=%0b exp occ=1 crdt=0",
               occ[0], crdt[0]);
    end
    step();
    total++;
    if (crdt[0] !== 1'b1 || occ[0] !== 4'd0 || ovld[0] !== 1'b0) begin
      bad++;
      $display("FAIL single_t3 crdt=%0b occ=%0d vld=%0b exp 1 0 0",
               crdt[0], occ[0], ovld[0]);
    end
    rdy[0] = 1'b0;
    step();
    total++;
    if (crdt[0] !== 1'b0) begin
      bad++;
      $display("FAIL single_t4 crdt=%0b exp=0", crdt[0]);
    end
  endtask

  task automatic test_fill();
    rdy[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send(0, 64'h100 + 64'(i), 512'h2000 + 512'(i));
      total++;
      if (crdt[0] !== 1'b0) begin
        bad++;
        $display("FAIL fill_crdt i=%0d got=%0b exp=0", i, crdt[0]);
      end
      step();
    end
    step();
    total++;
    if (occ[0] !== 4'd8 || ovld[0] !== 1'b1 || crdt[0] !== 1'b0) begin
      bad++;
      $display("FAIL fill_full occ=%0d vld=%0b crdt=%0b exp 8 1 0",
               occ[0], ovld[0], crdt[0]);
    end
    rdy[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (ovld[0] !== 1'b1 || oreq[0] !== 64'h100 + 64'(i) ||
          odbus[0] !== 512'h2000 + 512'(i)) begin
        bad++;
        $display("FAIL fill_drain i=%0d vld=%0b req=%0h dbus=%0h",
                 i, ovld[0], oreq[0], odbus[0]);
      end
      step();
      total++;
      if (crdt[0] !== 1'b1) begin
        bad++;
        $display("FAIL fill_crdt_pulse i=%0d got=%0b exp=1", i, crdt[0]);
      end
    end
    total++;
    if (ovld[0] !== 1'b0 || occ[0] !== 4'd0) begin
      bad++;
      $display("FAIL fill_empty vld=%0b occ=%0d exp 0 0", ovld[0], occ[0]);
    end
    rdy[0] = 1'b0;
    step();
    total++;
    if (crdt[0] !== 1'b0) begin
      bad++;
      $display("FAIL fill_crdt_end got=%0b exp=0", crdt[0]);
    end
  endtask

  task automatic test_full_push_pop();
    logic [63:0]  er;
    logic [511:0] ed;
    rdy[0] = 1'b0;
    load8(0, 64'h200, 512'h4000);
    total++;
    if (occ[0] !== 4'd8) begin
      bad++;
      $display("FAIL fpp_occ_pre got=%0d exp=8", occ[0]);
    end
    rdy[0] = 1'b1;
    send(0, 64'h77, 512'h3077);
    total++;
    if (oreq[0] !== 64'h200) begin
      bad++;
      $display("FAIL fpp_old_head got=%0h exp=200", oreq[0]);
    end
    step();
    total++;
    if (occ[0] !== 4'd8 || oerr[0] !== 1'b0) begin
      bad++;
      $display("FAIL fpp_after occ=%0d err=%0b exp 8 0", occ[0], oerr[0]);
    end
    for (int i = 1; i <= 8; i++) begin
      er = (i < 8) ? 64'h200 + 64'(i) : 64'h77;
      ed = (i < 8) ? 512'h4000 + 512'(i) : 512'h3077;
      total++;
      if (ovld[0] !== 1'b1 || oreq[0] !== er || odbus[0] !== ed) begin
        bad++;
        $display("FAIL fpp_drain i=%0d req=%0h dbus=%0h exp %0h %0h",
                 i, oreq[0], odbus[0], er, ed);
      end
      step();
    end
    rdy[0] = 1'b0;
    total++;
    if (occ[0] !== 4'd0 || ovld[0] !== 1'b0) begin
      bad++;
      $display("FAIL fpp_empty occ=%0d vld=%0b exp 0 0", occ[0], ovld[0]);
    end
    step();
  endtask

  task automatic test_overflow();
    int pops = 0;
    int crds = 0;
    rdy[0] = 1'b0;
    load8(0, 64'h300, 512'h5000);
    total++;
    if (oerr[0] !== 1'b0) begin
      bad++;
      $display("FAIL ovf_pre got=%0b exp=0", oerr[0]);
    end
    send(0, 64'h3FF, 512'h5FFF);
    step();
    total++;
    if (oerr[0] !== 1'b1 || occ[0] !== 4'd8) begin
      bad++;
      $display("FAIL ovf_set err=%0b occ=%0d exp 1 8", oerr[0], occ[0]);
    end
    repeat (3) step();
    total++;
    if (oerr[0] !== 1'b1) begin
      bad++;
      $display("FAIL ovf_sticky got=%0b exp=1", oerr[0]);
    end
    rdy[0] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (ovld[0]) begin
        total++;
        if (oreq[0] !== 64'h300 + 64'(pops) ||
            odbus[0] !== 512'h5000 + 512'(pops)) begin
          bad++;
          $display("FAIL ovf_drain n=%0d req=%0h dbus=%0h",
                   pops, oreq[0], odbus[0]);
        end
        pops++;
      end
      if (crdt[0]) crds++;
      step();
    end
    rdy[0] = 1'b0;
    total++;
    if (pops != 8 || crds != 8 || oerr[0] !== 1'b1) begin
      bad++;
      $display("FAIL ovf_counts pops=%0d crds=%0d err=%0b exp 8 8 1",
               pops, crds, oerr[0]);
    end
  endtask

  task automatic test_wrap(input int k);
    int           tx = 8;
    int           sent = 0;
    int           cyc = 0;
    int           sum;
    logic [63:0]  qr[$];
    logic [511:0] qd[$];
    logic [63:0]  r;
    logic [511:0] d;
    while ((sent < 50 || qr.size() != 0 || occ[k] != 4'd0 || crdt[k])
           && cyc < 3000) begin
      sum = tx + int'(occ[k]) + int'(crdt[k]);
      total++;
      if (sum != 8) begin
        bad++;
        $display("FAIL wrap%0d_invariant cyc=%0d got=%0d exp=8",
                 lat[k], cyc, sum);
      end
      rdy[k] = 1'($urandom_range(0, 1));
      if (ovld[k] && rdy[k]) begin
        total++;
        if (qr.size() == 0) begin
          bad++;
          $display("FAIL wrap%0d_extra req=%0h exp none", lat[k], oreq[k]);
        end else begin
          r = qr.pop_front();
          d = qd.pop_front();
          if (oreq[k] !== r || odbus[k] !== d) begin
            bad++;
            $display("FAIL wrap%0d_data req=%0h dbus=%0h exp %0h %0h",
                     lat[k], oreq[k], odbus[k], r, d);
          end
        end
      end
      if (sent < 50 && tx > 0 && $urandom_range(0, 2) != 0) begin
        r = {$urandom, $urandom};
        d = {448'(cyc), r};
        send(k, r, d);
        qr.push_back(r);
        qd.push_back(d);
        tx--;
        sent++;
      end
      if (crdt[k]) tx++;
      step();
      cyc++;
    end
    rdy[k] = 1'b0;
    total++;
    if (cyc >= 3000 || sent != 50 || oerr[k] !== 1'b0) begin
      bad++;
      $display("FAIL wrap%0d_end cyc=%0d sent=%0d err=%0b exp <3000 50 0",
               lat[k], cyc, sent, oerr[k]);
    end
  endtask

  task automatic test_reset_midstream();
    rdy[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(0, 64'h400 + 64'(i), 512'h6000 + 512'(i));
      step();
    end
    step();
    send(0, 64'h405, 512'h6005);
    step();
    total++;
    if (occ[0] !== 4'd6 || ovld[0] !== 1'b1 || oerr[0] !== 1'b1) begin
      bad++;
      $display("FAIL mid_pre occ=%0d vld=%0b err=%0b exp 6 1 1",
               occ[0], ovld[0], oerr[0]);
    end
    #2 mhreset_n = 1'b0;
    rdy[0] = 1'b1;
    #1;
    total++;
    if ({ovld[0], crdt[0], occ[0], oerr[0]} !== 7'd0) begin
      bad++;
      $display("FAIL mid_async outs got=%0h exp=0",
               {ovld[0], crdt[0], occ[0], oerr[0]});
    end
    repeat (2) step();
    @(negedge mclk) mhreset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      total++;
      if (crdt[0] !== 1'b0 || ovld[0] !== 1'b0 || occ[0] !== 4'd0) begin
        bad++;
        $display("FAIL mid_release c=%0d crdt=%0b vld=%0b occ=%0d exp 0",
                 c, crdt[0], ovld[0], occ[0]);
      end
    end
    rdy[0] = 1'b0;
    test_single();
  endtask

  initial begin
    mhreset_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vld[k]  = 1'b0;
      rdy[k]  = 1'b0;
      req[k]  = '0;
      dbus[k] = '0;
      for (int j = 0; j < 4; j++) sched[k][j] = '0;
    end
    test_reset();
    test_single();
    test_fill();
    test_full_push_pop();
    test_overflow();
    test_wrap(1);
    test_wrap(2);
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
